ship_controller: RTL and testbench
==================================

# ship_controller

Sequences the player ship for the Space Invaders core. Paces debounced left/right inputs into single-cycle move strobes for the ship position register and gates fire requests into a one-shot handshake with the bullet logic. Runs the ship life cycle (alive, exploding, respawning, game over) and tracks remaining lives. Sits between the button debouncers, collision detection and the ship, bullet and renderer blocks.

## Interface

Parameters:
- MOVE_DIV, 3600000, clock cycles per move tick (100 ms at 36 MHz); ≥2
- EXPLODE_CYCLES, 18000000, cycles spent in EXPLODING; ≥1
- RESPAWN_CYCLES, 36000000, cycles spent in RESPAWN; ≥1
- LIVES, 3, lives at reset and new game; 1..3

Ports:
- i_clk_36MHz  in  1  system clock; single clock domain
- i_reset  in  1  reset, synchronous and active-high
- i_left_debounced  in  1  left button level
- i_right_debounced  in  1  right button level
- i_fire_debounced  in  1  fire button level
- i_ship_hit  in  1  one-cycle pulse from collision detection
- i_new_game  in  1  one-cycle pulse, start a new game
- i_bullet_busy  in  1  player bullet in flight
- o_move_left  out  1  one-cycle strobe, step ship left
- o_move_right  out  1  one-cycle strobe, step ship right
- o_fire  out  1  one-cycle strobe, launch bullet
- o_ship_recenter  out  1  one-cycle strobe, return ship to start column
- o_ship_visible  out  1  high only in ALIVE
- o_exploding  out  1  high only in EXPLODING
- o_game_over  out  1  high only in GAME_OVER
- o_lives  out  2  remaining lives
- o_state  out  2  ALIVE=0, EXPLODING=1, RESPAWN=2, GAME_OVER=3

## Operation

- Reset: state ALIVE, o_lives=LIVES, prescaler=0, phase timer=0, fire pending=0, fire edge register=0. All strobes are 0. o_ship_visible=1. o_exploding=0. o_game_over=0.
- The prescaler is free-running (0..MOVE_DIV-1, wraps to 0). A tick occurs in the cycle where count==MOVE_DIV-1. The prescaler runs in every state.
- Move arbitration on a tick in ALIVE: left only gives o_move_left; right only gives o_move_right; both or neither gives no strobe. There is never a move outside ALIVE. Ship limits are enforced by the ship block, not here.
- Fire: a rising edge of i_fire_debounced sets pending. At most one request is pending; further edges while pending are absorbed. A pending request issues o_fire when state is ALIVE and i_bullet_busy=0, then pending clears. Pending clears on any exit from ALIVE.
- ALIVE: on i_ship_hit, o_lives decrements and the state moves to EXPLODING, with the timer loaded to EXPLODE_CYCLES-1.
- EXPLODING: the timer counts down. At 0: if o_lives==0, go to GAME_OVER; else go to RESPAWN with the timer loaded to RESPAWN_CYCLES-1 and o_ship_recenter pulsed.
- RESPAWN: the timer counts down. At 0, go to ALIVE.
- GAME_OVER: on i_new_game, set o_lives=LIVES, go to RESPAWN with the timer loaded, and pulse o_ship_recenter.
- i_ship_hit is ignored outside ALIVE. i_new_game is ignored outside GAME_OVER.
- Simultaneous events:
  - Hit and tick in the same cycle: no move.
  - Hit and fire issue in the same cycle: hit wins, no o_fire, pending cleared.
  - Left and right together: no move.
- i_reset mid-operation overrides everything: the next cycle holds the reset values, and in-flight timers and pending fire are discarded.

## Timing

- All outputs are registered. A decision taken on inputs in cycle n appears in cycle n+1, high for exactly one cycle for strobes.
- First tick is at cycle MOVE_DIV-1 after reset deassertion. Move strobes follow every MOVE_DIV cycles while a single button is held.
- Fire latency: if the edge is in cycle n and the state is ALIVE with bullet not busy, o_fire is high in cycle n+1. Otherwise o_fire comes in the cycle after the first qualifying cycle.
- Hit in cycle n: o_state=EXPLODING and o_lives decremented in cycle n+1. EXPLODING lasts exactly EXPLODE_CYCLES cycles.
- RESPAWN lasts exactly RESPAWN_CYCLES cycles. o_ship_recenter is high in the first RESPAWN cycle.
- o_lives never underflows: a hit with o_lives==1 gives 0, then GAME_OVER.

## Test plan

Use MOVE_DIV=4, EXPLODE_CYCLES=5, RESPAWN_CYCLES=3, LIVES=3.
- Hold left for 12 cycles after reset → o_move_left high at cycles 4, 8, 12 only. Holding both buttons over the same window → no move strobes.
- Fire edge with i_bullet_busy=0 → o_fire next cycle. Fire twice while busy, then drop busy → exactly one o_fire, the cycle after busy falls.
- Hit in ALIVE → o_lives 3→2, EXPLODING for 5 cycles, then RESPAWN with one o_ship_recenter pulse for 3 cycles, then ALIVE. Left held meanwhile → no moves until ALIVE.
- Three hits, each in ALIVE → GAME_OVER with o_lives=0. Further hits are ignored. i_new_game → o_lives=3, RESPAWN, recenter pulse.
- Hit coincident with a pending fire and a tick → no o_fire, no move, pending cleared. A second hit during EXPLODING → o_lives unchanged.
- i_reset pulsed mid-EXPLODING → next cycle state ALIVE, o_lives=3, all strobes 0, prescaler restarted (next tick at cycle 4 after release).

Source files
------------

// File: rtl/ship_controller.sv
// ship_controller
//   Player-ship sequencer. Turns held left/right buttons into paced move
//   strobes and fire-button edges into a one-shot bullet launch. Runs the
//   ship life cycle (ALIVE -> EXPLODING -> RESPAWN / GAME_OVER) and tracks
//   the remaining lives.
//
// Ports
//   i_clk_36MHz        system clock
//   i_reset            synchronous, active-high reset
//   i_left_debounced   left button level
//   i_right_debounced  right button level
//   i_fire_debounced   fire button level
//   i_ship_hit         one-cycle hit pulse from collision detection
//   i_new_game         one-cycle pulse, restart after game over
//   i_bullet_busy      player bullet still in flight
//   o_move_left        one-cycle strobe, step ship left
//   o_move_right       one-cycle strobe, step ship right
//   o_fire             one-cycle strobe, launch bullet
//   o_ship_recenter    one-cycle strobe, return ship to start column
//   o_ship_visible     high in ALIVE
//   o_exploding        high in EXPLODING
//   o_game_over        high in GAME_OVER
//   o_lives            remaining lives
//   o_state            ALIVE=0, EXPLODING=1, RESPAWN=2, GAME_OVER=3
module ship_controller #(
    parameter int MOVE_DIV       = 3600000,
    parameter int EXPLODE_CYCLES = 18000000,
    parameter int RESPAWN_CYCLES = 36000000,
    parameter int LIVES          = 3
) (
    input  logic       i_clk_36MHz,
    input  logic       i_reset,
    input  logic       i_left_debounced,
    input  logic       i_right_debounced,
    input  logic       i_fire_debounced,
    input  logic       i_ship_hit,
    input  logic       i_new_game,
    input  logic       i_bullet_busy,
    output logic       o_move_left,
    output logic       o_move_right,
    output logic       o_fire,
    output logic       o_ship_recenter,
    output logic       o_ship_visible,
    output logic       o_exploding,
    output logic       o_game_over,
    output logic [1:0] o_lives,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        ST_ALIVE     = 2'd0,
        ST_EXPLODING = 2'd1,
        ST_RESPAWN   = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    localparam int PW   = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int TMAX = (EXPLODE_CYCLES > RESPAWN_CYCLES) ? EXPLODE_CYCLES : RESPAWN_CYCLES;
    // Timer only ever holds load values (duration-1), so TMAX-1 must fit.
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [PW-1:0] PRESC_LAST   = PW'(MOVE_DIV - 1);
    localparam logic [TW-1:0] EXPLODE_LOAD = TW'(EXPLODE_CYCLES - 1);
    localparam logic [TW-1:0] RESPAWN_LOAD = TW'(RESPAWN_CYCLES - 1);
    localparam logic [1:0]    LIVES_INIT   = 2'(LIVES);

    state_t          r_state;
    logic [1:0]      r_lives;
    logic [PW-1:0]   r_presc;
    logic [TW-1:0]   r_timer;
    logic            r_pending;
    logic            r_fire_q;
    logic            r_move_left;
    logic            r_move_right;
    logic            r_fire;
    logic            r_recenter;

    state_t          w_state_nxt;
    logic [1:0]      w_lives_nxt;
    logic [PW-1:0]   w_presc_nxt;
    logic [TW-1:0]   w_timer_nxt;
    logic            w_pending_nxt;
    logic            w_move_left;
    logic            w_move_right;
    logic            w_fire;
    logic            w_recenter;
    logic            w_tick;
    logic            w_fire_edge;
    logic            w_want_fire;

    always_ff @(posedge i_clk_36MHz) begin
        if (i_reset) begin
            r_state      <= ST_ALIVE;
            r_lives      <= LIVES_INIT;
            r_presc      <= '0;
            r_timer      <= '0;
            r_pending    <= 1'b0;
            r_fire_q     <= 1'b0;
            r_move_left  <= 1'b0;
            r_move_right <= 1'b0;
            r_fire       <= 1'b0;
            r_recenter   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_lives      <= w_lives_nxt;
            r_presc      <= w_presc_nxt;
            r_timer      <= w_timer_nxt;
            r_pending    <= w_pending_nxt;
            r_fire_q     <= i_fire_debounced;
            r_move_left  <= w_move_left;
            r_move_right <= w_move_right;
            r_fire       <= w_fire;
            r_recenter   <= w_recenter;
        end
    end

    always_comb begin
        w_tick        = (r_presc == PRESC_LAST);
        w_fire_edge   = i_fire_debounced & ~r_fire_q;
        // An edge arriving this cycle counts as pending immediately, so a
        // qualifying state lets it launch with one cycle of latency.
        w_want_fire   = r_pending | w_fire_edge;

        w_presc_nxt   = w_tick ? '0 : r_presc + 1'b1;
        w_state_nxt   = r_state;
        w_lives_nxt   = r_lives;
        w_timer_nxt   = r_timer;
        w_pending_nxt = w_want_fire;
        w_move_left   = 1'b0;
        w_move_right  = 1'b0;
        w_fire        = 1'b0;
        w_recenter    = 1'b0;

        unique case (r_state)
            ST_ALIVE: begin
                if (i_ship_hit) begin
                    // Hit beats any move or fire decided in the same cycle.
                    w_state_nxt   = ST_EXPLODING;
                    w_timer_nxt   = EXPLODE_LOAD;
                    w_pending_nxt = 1'b0;
                    if (r_lives != 2'd0)
                        w_lives_nxt = r_lives - 2'd1;
                end else begin
                    if (w_tick && (i_left_debounced ^ i_right_debounced)) begin
                        w_move_left  = i_left_debounced;
                        w_move_right = i_right_debounced;
                    end
                    if (w_want_fire && !i_bullet_busy) begin
                        w_fire        = 1'b1;
                        w_pending_nxt = 1'b0;
                    end
                end
            end
            ST_EXPLODING: begin
                if (r_timer == '0) begin
                    if (r_lives == 2'd0) begin
                        w_state_nxt = ST_GAME_OVER;
                    end else begin
                        w_state_nxt = ST_RESPAWN;
                        w_timer_nxt = RESPAWN_LOAD;
                        w_recenter  = 1'b1;
                    end
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            ST_RESPAWN: begin
                if (r_timer == '0)
                    w_state_nxt = ST_ALIVE;
                else
                    w_timer_nxt = r_timer - 1'b1;
            end
            ST_GAME_OVER: begin
                if (i_new_game) begin
                    w_lives_nxt = LIVES_INIT;
                    w_state_nxt = ST_RESPAWN;
                    w_timer_nxt = RESPAWN_LOAD;
                    w_recenter  = 1'b1;
                end
            end
            default: w_state_nxt = ST_ALIVE;
        endcase
    end

    assign o_move_left     = r_move_left;
    assign o_move_right    = r_move_right;
    assign o_fire          = r_fire;
    assign o_ship_recenter = r_recenter;
    assign o_ship_visible  = (r_state == ST_ALIVE);
    assign o_exploding     = (r_state == ST_EXPLODING);
    assign o_game_over     = (r_state == ST_GAME_OVER);
    assign o_lives         = r_lives;
    assign o_state         = r_state;

endmodule

// File: tb/tb_ship_controller.sv
// Bench for ship_controller: a hand-derived vector table for the planned
// scenarios, a hand-written run to game over, then randomized traffic
// checked against a phase/elapsed-time reference model.
module tb_ship_controller;

    localparam int MD = 4;
    localparam int EC = 5;
    localparam int RC = 3;
    localparam int LV = 3;

    localparam logic [6:0] I_RST  = 7'b1000000;
    localparam logic [6:0] I_L    = 7'b0100000;
    localparam logic [6:0] I_R    = 7'b0010000;
    localparam logic [6:0] I_F    = 7'b0001000;
    localparam logic [6:0] I_HIT  = 7'b0000100;
    localparam logic [6:0] I_NG   = 7'b0000010;
    localparam logic [6:0] I_BUSY = 7'b0000001;

    localparam logic [3:0] S_ML = 4'b1000;
    localparam logic [3:0] S_MR = 4'b0100;
    localparam logic [3:0] S_FI = 4'b0010;
    localparam logic [3:0] S_RC = 4'b0001;

    logic       clk = 1'b0;
    logic       rst, l, r, f, hit, ng, busy;
    logic       o_ml, o_mr, o_fi, o_rc, o_vis, o_exp, o_go;
    logic [1:0] o_lives, o_state;

    always #5 clk = ~clk;

    ship_controller #(
        .MOVE_DIV(MD), .EXPLODE_CYCLES(EC), .RESPAWN_CYCLES(RC), .LIVES(LV)
    ) dut (
        .i_clk_36MHz(clk), .i_reset(rst),
        .i_left_debounced(l), .i_right_debounced(r), .i_fire_debounced(f),
        .i_ship_hit(hit), .i_new_game(ng), .i_bullet_busy(busy),
        .o_move_left(o_ml), .o_move_right(o_mr), .o_fire(o_fi),
        .o_ship_recenter(o_rc), .o_ship_visible(o_vis), .o_exploding(o_exp),
        .o_game_over(o_go), .o_lives(o_lives), .o_state(o_state)
    );

    typedef struct {
        logic [6:0] in;
        logic [3:0] s;
        logic [1:0] st;
        logic [1:0] lv;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state
    int   m_cyc, m_phase, m_elapsed, m_lives;
    logic m_pend, m_prev;

    task automatic add(input logic [6:0] in, input logic [3:0] s, input int st, input int lv);
        vec_t v;
        v.in = in; v.s = s; v.st = 2'(st); v.lv = 2'(lv);
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [6:0] in);
        {rst, l, r, f, hit, ng, busy} = in;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] dut_vec();
        return {o_ml, o_mr, o_fi, o_rc, o_vis, o_exp, o_go, o_lives, o_state};
    endfunction

    function automatic logic [10:0] exp_vec(logic [3:0] s, logic [1:0] st, logic [1:0] lv);
        return {s, st == 2'd0, st == 2'd1, st == 2'd3, lv, st};
    endfunction

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] got;
        got = dut_vec();
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got ml,mr,fi,rc,vis,exp,go,lives,state=%b want %b", name, got, exp);
        end
    endtask

    // Behavioural model: phases tracked by elapsed cycle counts against the
    // required durations; move pacing from the cycle count since reset.
    task automatic model_step(input logic [6:0] in, output logic [10:0] exp);
        logic       tick, edge_, want;
        logic [3:0] s;
        s = 4'b0;
        if (in[6]) begin
            m_cyc = 0; m_phase = 0; m_elapsed = 0; m_lives = LV;
            m_pend = 1'b0; m_prev = 1'b0;
        end else begin
            tick   = (m_cyc % MD) == MD - 1;
            edge_  = in[3] && !m_prev;
            m_prev = in[3];
            want   = m_pend || edge_;
            m_pend = want;
            case (m_phase)
                0: begin
                    if (in[2]) begin
                        m_lives--; m_phase = 1; m_elapsed = 0; m_pend = 1'b0;
                    end else begin
                        if (tick && in[5] && !in[4]) s[3] = 1'b1;
                        if (tick && in[4] && !in[5]) s[2] = 1'b1;
                        if (want && !in[0]) begin s[1] = 1'b1; m_pend = 1'b0; end
                    end
                end
                1: begin
                    m_elapsed++;
                    if (m_elapsed == EC) begin
                        m_elapsed = 0;
                        if (m_lives == 0) m_phase = 3;
                        else begin m_phase = 2; s[0] = 1'b1; end
                    end
                end
                2: begin
                    m_elapsed++;
                    if (m_elapsed == RC) begin m_elapsed = 0; m_phase = 0; end
                end
                default: begin
                    if (in[1]) begin m_lives = LV; m_phase = 2; m_elapsed = 0; s[0] = 1'b1; end
                end
            endcase
            m_cyc++;
        end
        exp = exp_vec(s, 2'(m_phase), 2'(m_lives));
    endtask

    initial begin
        logic [10:0] e;
        logic        cl, cr, cf, cb;
        logic [6:0]  in;
        int          n;

        drive(I_RST);
        step();

        // ---- hold left after reset: moves at cycles 4, 8, 12
        add(I_RST, 0, 0, 3);
        for (int k = 0; k < 12; k++) add(I_L, (k % 4 == 3) ? S_ML : 4'b0, 0, 3);
        // ---- both held: no moves; then right only
        add(I_RST, 0, 0, 3);
        for (int k = 0; k < 8; k++) add(I_L | I_R, 0, 0, 3);
        for (int k = 8; k < 12; k++) add(I_R, (k == 11) ? S_MR : 4'b0, 0, 3);
        // ---- fire: immediate, then two edges while busy give one launch
        add(I_RST, 0, 0, 3);
        add(I_F, S_FI, 0, 3);
        add(I_F, 0, 0, 3);
        add(I_BUSY, 0, 0, 3);
        add(I_F | I_BUSY, 0, 0, 3);
        add(I_BUSY, 0, 0, 3);
        add(I_F | I_BUSY, 0, 0, 3);
        add(0, S_FI, 0, 3);
        add(0, 0, 0, 3);
        // ---- hit, explode 5, respawn 3 with recenter, left held throughout
        add(I_RST, 0, 0, 3);
        add(I_L | I_HIT, 0, 1, 2);
        for (int k = 1; k < 5; k++) add(I_L, 0, 1, 2);
        add(I_L, S_RC, 2, 2);
        add(I_L, 0, 2, 2);
        add(I_L, 0, 2, 2);
        add(I_L, 0, 0, 2);
        add(I_L, 0, 0, 2);
        add(I_L, 0, 0, 2);
        add(I_L, S_ML, 0, 2);
        // ---- second and third hit down to game over
        add(I_HIT, 0, 1, 1);
        for (int k = 0; k < 4; k++) add(0, 0, 1, 1);
        add(0, S_RC, 2, 1);
        add(0, 0, 2, 1);
        add(0, 0, 2, 1);
        add(0, 0, 0, 1);
        add(I_HIT, 0, 1, 0);
        for (int k = 0; k < 4; k++) add(0, 0, 1, 0);
        add(0, 0, 3, 0);
        add(I_HIT, 0, 3, 0);           // ignored in GAME_OVER
        add(I_NG, S_RC, 2, 3);
        add(0, 0, 2, 3);
        add(0, 0, 2, 3);
        add(0, 0, 0, 3);
        add(I_NG, 0, 0, 3);            // ignored in ALIVE
        add(I_HIT, 0, 1, 2);
        add(I_HIT, 0, 1, 2);           // second hit while exploding
        // ---- reset mid-EXPLODING, prescaler restarts
        add(I_RST, 0, 0, 3);
        for (int k = 0; k < 4; k++) add(I_L, (k == 3) ? S_ML : 4'b0, 0, 3);
        // ---- hit with pending fire and a tick in the same cycle
        add(I_RST, 0, 0, 3);
        add(I_F | I_BUSY, 0, 0, 3);
        add(I_BUSY, 0, 0, 3);
        add(I_L | I_BUSY, 0, 0, 3);
        add(I_L | I_HIT, 0, 1, 2);
        for (int k = 0; k < 4; k++) add(0, 0, 1, 2);
        add(0, S_RC, 2, 2);
        add(0, 0, 2, 2);
        add(0, 0, 2, 2);
        add(0, 0, 0, 2);
        add(0, 0, 0, 2);               // pending was discarded: no fire

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].in);
            step();
            check($sformatf("vec%0d", i), exp_vec(tbl[i].s, tbl[i].st, tbl[i].lv));
        end

        // ---- hand sequence: hit whenever alive until game over
        drive(I_RST);
        step();
        n = 0;
        while (!o_go && n < 200) begin
            drive((o_state == 2'd0) ? I_HIT : 7'b0);
            step();
            n++;
        end
        n_cmp++;
        if (n != 24) begin
            n_bad++;
            $display("FAIL gameover_cycles: got %0d want 24", n);
        end
        n_cmp++;
        if ({o_go, o_lives, o_vis, o_exp} !== 5'b10000) begin
            n_bad++;
            $display("FAIL gameover_flags: got go,lives,vis,exp=%b want 10000",
                     {o_go, o_lives, o_vis, o_exp});
        end

        // ---- randomized traffic against the reference model
        cl = 0; cr = 0; cf = 0; cb = 0;
        drive(I_RST);
        model_step(I_RST, e);
        step();
        check("rand_reset", e);
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(7) == 0) cl = ~cl;
            if ($urandom_range(7) == 0) cr = ~cr;
            if ($urandom_range(2) == 0) cf = ~cf;
            if ($urandom_range(5) == 0) cb = ~cb;
            in = {($urandom_range(499) == 0), cl, cr, cf,
                  ($urandom_range(39) == 0), ($urandom_range(9) == 0), cb};
            drive(in);
            model_step(in, e);
            step();
            check($sformatf("rand%0d", c), e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
